// File: rtl/baud_gen_r.sv
// Oversampled UART baud clock generator with four selectable rates.
// baud_clk is a 50% square wave whose half-period is a rounded clk count.
module baud_gen_r #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_rate,
  output logic       baud_clk
);

  localparam int F0 = 2400 * OVERSAMPLE;
  localparam int F1 = 4800 * OVERSAMPLE;
  localparam int F2 = 9600 * OVERSAMPLE;
  localparam int F3 = 19200 * OVERSAMPLE;

  localparam int T0 = (CLK_FREQ + F0) / (2 * F0);
  localparam int T1 = (CLK_FREQ + F1) / (2 * F1);
  localparam int T2 = (CLK_FREQ + F2) / (2 * F2);
  localparam int T3 = (CLK_FREQ + F3) / (2 * F3);

  // slowest rate has the largest count; one spare bit keeps the >= safe
  localparam int CW = $clog2(T0) + 1;

  logic [CW-1:0] cnt_q, cnt_d, lim;
  logic          clk_q, clk_d;
  logic          wrap;

  always_comb begin
    case (baud_rate)
      2'b00:   lim = CW'(T0 - 1);
      2'b01:   lim = CW'(T1 - 1);
      2'b10:   lim = CW'(T2 - 1);
      default: lim = CW'(T3 - 1);
    endcase
  end

  // >= so a switch to a faster rate wraps at once
  assign wrap = (cnt_q >= lim);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    clk_d = clk_q;
    if (wrap) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign baud_clk = clk_q;

endmodule

// File: tb/tb_baud_gen_r.sv
// Bench for baud_gen_r: toggle intervals checked against a scoreboard queue.
// Sweep section measures average baud_clk period per rate.
module tb_baud_gen_r;

  logic       clk;
  logic       rst;
  logic [1:0] baud_rate;
  logic       baud_clk;

  baud_gen_r dut (
    .clk      (clk),
    .rst      (rst),
    .baud_rate(baud_rate),
    .baud_clk (baud_clk)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t q[$];

  int   n_vec;
  int   n_err;
  int   ecnt;
  int   mark;
  logic prev;
  logic rose;

  int tval [4] = '{651, 326, 163, 81};

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int n, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // one clk edge; pop/compare the interval since the last mark on a toggle
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    ecnt++;
    rose = (prev === 1'b0) && (baud_clk === 1'b1);
    if (baud_clk !== prev && q.size() != 0) begin
      e = q.pop_front();
      check(e.tag, ecnt - mark, e.exp);
      mark = ecnt;
    end
    prev = baud_clk;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (q.size() != 0) begin
      check("timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_reset(input logic [1:0] r, input string tag);
    baud_rate = r;
    rst = 1'b1;
    repeat (5) tick();
    check(tag, int'(baud_clk), 0);
    rst = 1'b0;
    mark = ecnt;
  endtask

  task automatic sweep(input logic [1:0] r, input int cycles);
    int n, first, last;
    n = 0;
    first = 0;
    last = 0;
    baud_rate = r;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (rose) begin
        if (n == 0) first = ecnt;
        last = ecnt;
        n++;
      end
    end
    if (n < 2) check($sformatf("sweep%0d_rises", r), n, 2);
    else check($sformatf("sweep%0d_period", r),
               (last - first) / (n - 1), 2 * tval[r]);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    ecnt = 0;
    mark = 0;
    rose = 1'b0;
    rst = 1'b1;
    baud_rate = 2'b00;
    prev = baud_clk;

    for (int r = 0; r < 4; r++) begin
      do_reset(2'(r), $sformatf("rst%0d_low", r));
      push($sformatf("rate%0d_first", r), 1, tval[r]);
      push($sformatf("rate%0d_half", r), 4, tval[r]);
      wait_drain(4000);
    end

    do_reset(2'b00, "sw_rst_low");
    push("sw_fast_first", 1, 501);
    push("sw_fast_half", 3, 81);
    repeat (500) tick();
    baud_rate = 2'b11;
    wait_drain(2000);
    repeat (40) tick();
    baud_rate = 2'b00;
    push("sw_slow_first", 1, 651);
    push("sw_slow_half", 1, 651);
    wait_drain(3000);

    do_reset(2'b10, "mid_rst_low");
    push("mid_first", 1, 163);
    wait_drain(1000);
    repeat (50) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_clear", int'(baud_clk), 0);
    rst = 1'b0;
    mark = ecnt;
    push("mid_after", 2, 163);
    wait_drain(1000);

    sweep(2'b00, 15000);
    sweep(2'b01, 7500);
    sweep(2'b10, 5000);
    sweep(2'b11, 3750);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/baud_gen_r.md
BAUD_GEN_R -- requirements
Module: baud_gen_r

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, default 16, receiver oversampling factor applied to every baud rate.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 baud_rate  input  2  rate select: 00=2400, 01=4800, 10=9600, 11=19200 baud.
REQ-006 baud_clk  output  1  oversampled baud clock, square wave at baud*OVERSAMPLE Hz, driven directly from a flop.

Function
REQ-007 Half-period count T(sel) SHALL be elaboration-time constants: T = (CLK_FREQ + baud*OVERSAMPLE) / (2*baud*OVERSAMPLE), integer division (round to nearest, half up).
REQ-008 With defaults, T SHALL be: 00 -> 651, 01 -> 326, 10 -> 163, 11 -> 81 clk cycles.
REQ-009 A free-running counter, wide enough for the largest T (min 11 bits at defaults), SHALL increment by 1 each clk cycle when not in reset.
REQ-010 When counter >= T(baud_rate)-1: counter SHALL load 0 and baud_clk SHALL toggle on the same edge.
REQ-011 Full baud_clk period SHALL be 2*T clk cycles, duty exactly 50% (T high, T low).
REQ-012 baud_rate SHALL be sampled combinationally every cycle; no registering or handshaking of the select.
REQ-013 On a baud_rate change, the current count SHALL carry over; the first half-period after the change lasts T_new - counter cycles, minimum 1 cycle.
REQ-014 If the counter already exceeds T_new-1 after a change to a faster rate, the >= compare SHALL force a wrap and toggle on the next edge; the counter SHALL never run away.
REQ-015 No glitches: baud_clk changes only on rising clk edges.

Reset
REQ-016 While rst=1 at a rising clk edge: counter <= 0 and baud_clk <= 0.
REQ-017 rst SHALL take priority over counting and toggling.
REQ-018 After rst falls, the first baud_clk rising edge SHALL occur on the T(baud_rate)-th rising clk edge.
REQ-019 Reset asserted mid-period SHALL abort the period; no partial-period memory is kept.

Verification
REQ-020 clk 50 MHz, rst=1 for 5 cycles, then 0, baud_rate=00 -> baud_clk 0 during reset; first rise 651 cycles after release; period 1302 cycles (26.04 us).
REQ-021 baud_rate=01 from reset -> period 652 cycles (13.04 us), high 326 / low 326.
REQ-022 baud_rate=10 -> period 326 cycles (6.52 us); baud_rate=11 -> period 162 cycles (3.24 us); high time equals low time in both.
REQ-023 Switch 00 -> 11 at counter=500 -> baud_clk toggles on the next edge, then every 81 cycles; switch 11 -> 00 mid-count -> next toggle when counter reaches 650.
REQ-024 Assert rst for 1 cycle mid-high-phase at baud_rate=10 -> baud_clk 0 on the following edge; next rise exactly 163 cycles after rst deasserts.
REQ-025 Sweep baud_rate 00, 01, 10, 11, spending 300 us, 150 us, 100 us and 75 us on each -> measured baud_clk frequencies 38.40 kHz, 76.69 kHz, 153.37 kHz and 308.64 kHz, within 1 clk-cycle period tolerance.
